// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - opcode, state and control-word definitions for the RV subset control units
//
// Purpose: shared encodings for the multi-cycle (and single-cycle) control units.
// Ports: none (package).
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_EXEC_I   = 4'd8,
    S_ALU_WB   = 4'd9,
    S_BRANCH   = 4'd10
  } state_e;

  typedef enum logic [1:0] {
    SRCB_REG    = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } alusrcb_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  typedef struct packed {
    logic     pc_write;
    logic     pc_write_cond;
    logic     pc_source;
    logic     iord;
    logic     mem_read;
    logic     mem_write;
    logic     ir_write;
    logic     mem_to_reg;
    logic     reg_write;
    logic     alu_src_a;
    alusrcb_e alu_src_b;
    aluop_e   alu_op;
  } ctrl_t;

  function automatic logic opcode_supported(input logic [6:0] op);
    return (op == OP_R) || (op == OP_LD) || (op == OP_SD) ||
           (op == OP_BEQ) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/multi_cycle_control_fsm_if.sv
// rtl/multi_cycle_control_fsm_if.sv - control-unit to datapath/memory bundle
//
// Purpose: groups sequencing inputs and datapath control outputs.
// master: the control unit (drives controls, status, counter).
// slave : the datapath/memory side (drives run, opcode, mem_ready).
interface multi_cycle_control_fsm_if #(
  parameter int RETIRE_W = 32
);
  logic                run;
  logic [6:0]          opcode;
  logic                mem_ready;
  logic                PCWrite;
  logic                PCWriteCond;
  logic                PCSource;
  logic                IorD;
  logic                MemRead;
  logic                MemWrite;
  logic                IRWrite;
  logic                MemtoReg;
  logic                RegWrite;
  logic                ALUSrcA;
  logic [1:0]          ALUSrcB;
  logic [1:0]          ALUOp;
  logic                busy;
  logic                illegal_op;
  logic [RETIRE_W-1:0] retired_cnt;

  modport master (
    input  run, opcode, mem_ready,
    output PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, busy, illegal_op,
           retired_cnt
  );

  modport slave (
    output run, opcode, mem_ready,
    input  PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, busy, illegal_op,
           retired_cnt
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// rtl/mc_ctrl_decode.sv - state (+mem_ready) to control word decoder
//
// Purpose: Moore decode of the sequencer state into datapath controls.
// Ports: state (in), mem_ready (in, only gates IRWrite/PCWrite in FETCH), ctrl (out).
module mc_ctrl_decode
  import riscv_ctrl_pkg::*;
(
  input  state_e state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        // PC+4 and IR are only committed in the cycle the read data is valid
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
      end
      S_MEM_ADDR, S_EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALU_WB: begin
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control_fsm.sv
// rtl/multi_cycle_control_fsm.sv - multi-cycle sequencer for the RV datapath subset
//
// Purpose: steps fetch/decode/execute/memory/writeback, stalls on mem_ready,
//          counts retired instructions, flags unsupported opcodes.
// Ports: clk, reset_n (async active-low), bus (master modport: run, opcode,
//        mem_ready in; datapath controls, busy, illegal_op, retired_cnt out).
module multi_cycle_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  multi_cycle_control_fsm_if.master bus
);

  state_e              state_q;
  logic [RETIRE_W-1:0] cnt_q;
  ctrl_t               ctrl;
  state_e              after_retire;

  // Dropping run never aborts an instruction; it only decides where the
  // sequencer goes once the current one has finished.
  assign after_retire = bus.run ? S_FETCH : S_IDLE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE:     if (bus.run) state_q <= S_FETCH;
        S_FETCH:    if (bus.mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          case (bus.opcode)
            OP_LD, OP_SD: state_q <= S_MEM_ADDR;
            OP_R:         state_q <= S_EXEC_R;
            OP_ADDI:      state_q <= S_EXEC_I;
            OP_BEQ:       state_q <= S_BRANCH;
            default:      state_q <= after_retire;
          endcase
        end
        S_MEM_ADDR: state_q <= (bus.opcode == OP_SD) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:   if (bus.mem_ready) state_q <= S_MEM_WB;
        S_MEM_WR: begin
          if (bus.mem_ready) begin
            cnt_q   <= cnt_q + RETIRE_W'(1);
            state_q <= after_retire;
          end
        end
        S_EXEC_R, S_EXEC_I: state_q <= S_ALU_WB;
        S_MEM_WB, S_ALU_WB, S_BRANCH: begin
          cnt_q   <= cnt_q + RETIRE_W'(1);
          state_q <= after_retire;
        end
        default:    state_q <= S_IDLE;
      endcase
    end
  end

  mc_ctrl_decode u_decode (
    .state     (state_q),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.IorD        = ctrl.iord;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.MemtoReg    = ctrl.mem_to_reg;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.busy        = (state_q != S_IDLE);
  // IR is stable from FETCH onward, so this is a single-cycle pulse in DECODE
  assign bus.illegal_op  = (state_q == S_DECODE) && !opcode_supported(bus.opcode);
  assign bus.retired_cnt = cnt_q;

endmodule

// File: tb/tb_multi_cycle_control_fsm.sv
// tb/tb_multi_cycle_control_fsm.sv - testbench for multi_cycle_control_fsm
module tb_multi_cycle_control_fsm;

  localparam logic [6:0] C_R    = 7'b0110011;
  localparam logic [6:0] C_LD   = 7'b0000011;
  localparam logic [6:0] C_SD   = 7'b0100011;
  localparam logic [6:0] C_BEQ  = 7'b1100011;
  localparam logic [6:0] C_ADDI = 7'b0010011;
  localparam logic [6:0] C_BAD  = 7'b1111111;

  // {PCWrite,PCWriteCond,PCSource,IorD,MemRead,MemWrite,IRWrite,MemtoReg,
  //  RegWrite,ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],busy,illegal_op}
  localparam logic [15:0] W_IDLE   = 16'h0000;
  localparam logic [15:0] W_FWAIT  = 16'h0812;
  localparam logic [15:0] W_FETCH  = 16'h8A12;
  localparam logic [15:0] W_DEC    = 16'h0032;
  localparam logic [15:0] W_DECILL = 16'h0033;
  localparam logic [15:0] W_MADDR  = 16'h0062;
  localparam logic [15:0] W_MRD    = 16'h1802;
  localparam logic [15:0] W_MWB    = 16'h0182;
  localparam logic [15:0] W_MWR    = 16'h1402;
  localparam logic [15:0] W_EXR    = 16'h004A;
  localparam logic [15:0] W_EXI    = 16'h0062;
  localparam logic [15:0] W_AWB    = 16'h0082;
  localparam logic [15:0] W_BR     = 16'h6046;

  typedef struct {
    logic        run;
    logic [6:0]  op;
    logic        mr;
    logic [15:0] w;
    logic [31:0] cnt;
  } vec_t;

  typedef struct {
    logic [15:0] w;
    logic [31:0] cnt;
  } exp_t;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;
  vec_t vecs[$];
  exp_t sb[$];
  exp_t e;
  logic found;

  multi_cycle_control_fsm_if #(.RETIRE_W(32)) bus ();

  multi_cycle_control_fsm #(.RETIRE_W(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic run, logic [6:0] op, logic mr, logic [15:0] w, logic [31:0] cnt);
    vec_t v;
    v.run = run; v.op = op; v.mr = mr; v.w = w; v.cnt = cnt;
    return v;
  endfunction

  function automatic logic [15:0] sample_w();
    return {bus.PCWrite, bus.PCWriteCond, bus.PCSource, bus.IorD, bus.MemRead,
            bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegWrite, bus.ALUSrcA,
            bus.ALUSrcB, bus.ALUOp, bus.busy, bus.illegal_op};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset_n = 1'b0;
    bus.run = 1'b0;
    bus.opcode = '0;
    bus.mem_ready = 1'b0;

    // R-type, zero wait
    vecs.push_back(mk(1, C_R,    1, W_IDLE,   0));
    vecs.push_back(mk(1, C_R,    1, W_FETCH,  0));
    vecs.push_back(mk(1, C_R,    1, W_DEC,    0));
    vecs.push_back(mk(1, C_R,    1, W_EXR,    0));
    vecs.push_back(mk(1, C_R,    1, W_AWB,    0));
    // ld with two wait cycles in MEM_RD (7 cycles)
    vecs.push_back(mk(1, C_LD,   1, W_FETCH,  1));
    vecs.push_back(mk(1, C_LD,   1, W_DEC,    1));
    vecs.push_back(mk(1, C_LD,   1, W_MADDR,  1));
    vecs.push_back(mk(1, C_LD,   0, W_MRD,    1));
    vecs.push_back(mk(1, C_LD,   0, W_MRD,    1));
    vecs.push_back(mk(1, C_LD,   1, W_MRD,    1));
    vecs.push_back(mk(1, C_LD,   1, W_MWB,    1));
    // beq (3 cycles)
    vecs.push_back(mk(1, C_BEQ,  1, W_FETCH,  2));
    vecs.push_back(mk(1, C_BEQ,  1, W_DEC,    2));
    vecs.push_back(mk(1, C_BEQ,  1, W_BR,     2));
    // unsupported opcode
    vecs.push_back(mk(1, C_BAD,  1, W_FETCH,  3));
    vecs.push_back(mk(1, C_BAD,  1, W_DECILL, 3));
    // addi with one fetch wait, run dropped in EXEC_I
    vecs.push_back(mk(1, C_ADDI, 0, W_FWAIT,  3));
    vecs.push_back(mk(1, C_ADDI, 1, W_FETCH,  3));
    vecs.push_back(mk(1, C_ADDI, 1, W_DEC,    3));
    vecs.push_back(mk(0, C_ADDI, 1, W_EXI,    3));
    vecs.push_back(mk(0, C_ADDI, 1, W_AWB,    3));
    vecs.push_back(mk(0, C_ADDI, 1, W_IDLE,   4));
    vecs.push_back(mk(0, C_ADDI, 1, W_IDLE,   4));
    // sd with one write wait, run dropped on the final cycle
    vecs.push_back(mk(1, C_SD,   1, W_IDLE,   4));
    vecs.push_back(mk(1, C_SD,   1, W_FETCH,  4));
    vecs.push_back(mk(1, C_SD,   1, W_DEC,    4));
    vecs.push_back(mk(1, C_SD,   1, W_MADDR,  4));
    vecs.push_back(mk(1, C_SD,   0, W_MWR,    4));
    vecs.push_back(mk(0, C_SD,   1, W_MWR,    4));
    vecs.push_back(mk(0, C_SD,   1, W_IDLE,   5));

    repeat (2) @(posedge clk);
    #1;
    check("reset_ctrl", 32'(sample_w()), 32'(W_IDLE));
    check("reset_cnt", bus.retired_cnt, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      bus.run = vecs[i].run;
      bus.opcode = vecs[i].op;
      bus.mem_ready = vecs[i].mr;
      e.w = vecs[i].w;
      e.cnt = vecs[i].cnt;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("vec%0d_ctrl", i), 32'(sample_w()), 32'(e.w));
      check($sformatf("vec%0d_cnt", i), bus.retired_cnt, e.cnt);
    end

    // async reset while MemWrite is asserted
    bus.run = 1'b1;
    bus.opcode = C_SD;
    bus.mem_ready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk);
      #1;
      if (k >= 1) bus.mem_ready = 1'b0;
      @(negedge clk);
      if (bus.MemWrite === 1'b1) found = 1'b1;
    end
    check("memwr_reached", 32'(found), 32'd1);
    check("memwr_cnt_before", bus.retired_cnt, 32'd5);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_ctrl", 32'(sample_w()), 32'(W_IDLE));
    check("rst_async_cnt", bus.retired_cnt, 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_ctrl", 32'(sample_w()), 32'(W_IDLE));
    bus.run = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 32'(sample_w()), 32'(W_IDLE));
    check("post_rst_cnt", bus.retired_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
